// File: rtl/num_display.sv
// Binary-to-BCD display driver: sequential double-dabble conversion of Num
// feeding a 4-digit multiplexed, active-low 7-segment display with leading-zero blanking.
module num_display #(
    parameter int unsigned REFRESH_DIV = 100_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  Num,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [11:0] bcd,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    state_t        state;
    logic [7:0]    num_q;
    logic [7:0]    last_conv;
    logic [7:0]    conv_val;
    logic [7:0]    sh;
    logic [11:0]   scratch;
    logic [2:0]    iter;
    logic [11:0]   adjusted;
    logic [19:0]   shifted;
    logic [CW-1:0] refresh_cnt;
    logic [1:0]    idx;
    logic [3:0]    digit;
    logic          show;
    logic [3:0]    an_next;
    logic [6:0]    seg_next;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) num_q <= '0;
        else        num_q <= Num;
    end

    always_comb begin
        adjusted = {add3(scratch[11:8]), add3(scratch[7:4]), add3(scratch[3:0])};
        shifted  = {adjusted, sh} << 1;
    end

    // busy mirrors (state != IDLE) but is registered alongside the state transitions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            bcd       <= '0;
            last_conv <= '0;
            conv_val  <= '0;
            sh        <= '0;
            scratch   <= '0;
            iter      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (num_q != last_conv) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    sh       <= num_q;
                    conv_val <= num_q;
                    scratch  <= '0;
                    iter     <= '0;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    {scratch, sh} <= shifted;
                    iter          <= iter + 3'd1;
                    if (iter == 3'd7) state <= DONE;
                end
                DONE: begin
                    bcd       <= scratch;
                    last_conv <= conv_val;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            idx         <= '0;
        end else if (refresh_cnt == CW'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            idx         <= idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // Tens blank only when hundreds is also zero, so an interior zero stays visible
    always_comb begin
        digit = bcd[3:0];
        show  = 1'b1;
        case (idx)
            2'd0: begin
                digit = bcd[3:0];
                show  = 1'b1;
            end
            2'd1: begin
                digit = bcd[7:4];
                show  = (bcd[11:4] != 8'd0);
            end
            2'd2: begin
                digit = bcd[11:8];
                show  = (bcd[11:8] != 4'd0);
            end
            default: show = 1'b0;
        endcase
        an_next  = show ? ~(4'b0001 << idx) : 4'b1111;
        seg_next = show ? seg7(digit) : 7'b1111111;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
        end else begin
            an  <= an_next;
            seg <= seg_next;
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_num_display.sv
// Self-checking bench for num_display: conversion timing, BCD values and
// scanned display contents compared against a decimal-arithmetic reference.
module tb_num_display;

    logic        clk;
    logic        rst_n;
    logic [7:0]  Num;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [11:0] bcd;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    num_display #(.REFRESH_DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .Num   (Num),
        .an    (an),
        .seg   (seg),
        .dp    (dp),
        .bcd   (bcd),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1);
    end

    function automatic logic [11:0] to_bcd(input int n);
        return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    // Drive a new value and time the conversion relative to the edge that samples it (E = 0).
    task automatic convert(input logic [7:0] n);
        int rise;
        int fall;
        rise = -1;
        fall = -1;
        @(negedge clk);
        Num = n;
        for (int i = 0; i < 40 && fall < 0; i++) begin
            @(posedge clk);
            #1;
            if (rise < 0 && busy === 1'b1) rise = i;
            else if (rise >= 0 && busy === 1'b0) fall = i;
        end
        n_checks++;
        if (rise !== 1) begin
            n_fail++;
            $display("FAIL busy_rise(%0d): got edge %0d, need edge 1", n, rise);
        end
        n_checks++;
        if (fall !== 11) begin
            n_fail++;
            $display("FAIL busy_fall(%0d): got edge %0d, need edge 11", n, fall);
        end
        n_checks++;
        if (bcd !== to_bcd(n)) begin
            n_fail++;
            $display("FAIL bcd(%0d): got %h, need %h", n, bcd, to_bcd(n));
        end
    endtask

    // One full scan period: each shown digit occupies exactly 4 cycles, blanks fill the rest.
    task automatic check_scan(input int n);
        int h;
        int t;
        int u;
        int cnt_pos [4];
        int blanks;
        int p;
        int digit;
        bit shown [4];
        int exp_blank;
        h = n / 100;
        t = (n / 10) % 10;
        u = n % 10;
        shown[0] = 1'b1;
        shown[1] = !(h == 0 && t == 0);
        shown[2] = (h != 0);
        shown[3] = 1'b0;
        exp_blank = 0;
        for (int k = 0; k < 4; k++) begin
            cnt_pos[k] = 0;
            if (!shown[k]) exp_blank += 4;
        end
        blanks = 0;
        @(posedge clk);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            p = -1;
            case (an)
                4'b1110: p = 0;
                4'b1101: p = 1;
                4'b1011: p = 2;
                4'b0111: p = 3;
                default: p = -1;
            endcase
            n_checks++;
            if (dp !== 1'b1) begin
                n_fail++;
                $display("FAIL dp(%0d): got %b, need 1", n, dp);
            end
            if (an === 4'b1111) begin
                blanks++;
                n_checks++;
                if (seg !== 7'b1111111) begin
                    n_fail++;
                    $display("FAIL blank_seg(%0d): got %b, need 1111111", n, seg);
                end
            end else if (p < 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL an_onehot(%0d): got %b, need one-hot-low or 1111", n, an);
            end else begin
                cnt_pos[p]++;
                digit = (p == 0) ? u : (p == 1) ? t : h;
                n_checks++;
                if (!shown[p] || seg !== seg_tab[digit]) begin
                    n_fail++;
                    $display("FAIL digit_seg(%0d) slot %0d: got an %b seg %b, need slot shown=%0d seg %b",
                             n, p, an, seg, shown[p], seg_tab[digit]);
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (cnt_pos[k] !== (shown[k] ? 4 : 0)) begin
                n_fail++;
                $display("FAIL slot_cycles(%0d) slot %0d: got %0d, need %0d",
                         n, k, cnt_pos[k], shown[k] ? 4 : 0);
            end
        end
        n_checks++;
        if (blanks !== exp_blank) begin
            n_fail++;
            $display("FAIL blank_cycles(%0d): got %0d, need %0d", n, blanks, exp_blank);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_checks++;
        if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1 ||
            bcd !== 12'h000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got an %b seg %b dp %b bcd %h busy %b, need 1111 1111111 1 000 0",
                     tag, an, seg, dp, bcd, busy);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        Num   = 8'd0;
        #2 rst_n = 1'b0;
        #2 check_reset_outputs("reset_values");
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        convert(8'd128);
        check_scan(128);
    endtask

    task automatic test_single_digit;
        convert(8'd5);
        check_scan(5);
    endtask

    task automatic test_extremes;
        convert(8'd255);
        check_scan(255);
        convert(8'd0);
        check_scan(0);
    endtask

    task automatic test_back_to_back;
        logic [11:0] prev;
        logic [11:0] changes[$];
        int rises;
        logic pb;
        @(negedge clk);
        Num   = 8'd100;
        prev  = bcd;
        rises = 0;
        pb    = busy;
        for (int i = 0; i < 35; i++) begin
            @(posedge clk);
            #1;
            if (i == 4) Num = 8'd200;
            if (busy === 1'b1 && pb === 1'b0) rises++;
            pb = busy;
            if (bcd !== prev) begin
                changes.push_back(bcd);
                prev = bcd;
            end
        end
        n_checks++;
        if (changes.size() !== 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d bcd changes, need 2", changes.size());
        end else begin
            n_checks++;
            if (changes[0] !== 12'h100 || changes[1] !== 12'h200) begin
                n_fail++;
                $display("FAIL b2b_seq: got %h then %h, need 100 then 200", changes[0], changes[1]);
            end
        end
        n_checks++;
        if (rises !== 2 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_busy: got %0d bursts, busy %b, need 2 bursts, busy 0", rises, busy);
        end
        check_scan(200);
    endtask

    task automatic test_no_retrigger;
        int high;
        convert(8'd7);
        high = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b0) high++;
        end
        n_checks++;
        if (high !== 0 || bcd !== 12'h007) begin
            n_fail++;
            $display("FAIL no_retrigger: got %0d busy cycles, bcd %h, need 0 and 007", high, bcd);
        end
    endtask

    task automatic test_random;
        logic [7:0] last;
        logic [7:0] v;
        logic [7:0] fixed [4] = '{8'd9, 8'd10, 8'd99, 8'd101};
        last = 8'd7;
        for (int i = 0; i < 12; i++) begin
            v = (i < 4) ? fixed[i] : 8'($urandom_range(0, 255));
            if (v == last) v = v + 8'd1;
            convert(v);
            check_scan(int'(v));
            last = v;
        end
    endtask

    task automatic test_reset_mid_shift;
        @(negedge clk);
        Num = (bcd == 12'h077) ? 8'd78 : 8'd77;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset_mid_shift");
        Num = 8'd0;
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("reset_mid_shift_held");
        @(negedge clk);
        rst_n = 1'b1;
        convert(8'd128);
        check_scan(128);
    endtask

    initial begin
        test_reset;
        test_single_digit;
        test_extremes;
        test_back_to_back;
        test_no_retrigger;
        test_random;
        test_reset_mid_shift;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
